// File: rtl/add_seq_pkg.sv
// Shared definitions for the nibble-serial adder.
// State encodings and slice width.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

endpackage

// File: rtl/add_4.sv
// 4-bit ripple-carry adder slice.
// Purely combinational; one full adder per bit.
module add_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/add_nibble_seq.sv
// Wide adder built from one 4-bit slice, stepped one nibble per clock.
// Operands in and result out over valid/ready handshakes.
module add_nibble_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int CNT_W = $clog2(NIBS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               co_q, co_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [NIB_W-1:0]   nib_a, nib_b, slice_s;
    logic               slice_co;

    assign nib_a = a_q[{cnt_q, 2'b00} +: NIB_W];
    assign nib_b = b_q[{cnt_q, 2'b00} +: NIB_W];

    add_4 u_add_4 (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    sum_d   = '0;
                    co_d    = 1'b0;
                end
            end
            RUN: begin
                sum_d[{cnt_q, 2'b00} +: NIB_W] = slice_s;
                carry_d = slice_co;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    co_d    = slice_co;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are decoded from the next state so they stay registered.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            co_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            co_q        <= co_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign co        = co_q;

endmodule
